test_sequencer: RTL

Queues up to QUEUE_DEPTH test parameter sets and launches them back-to-back on the memory-test control datapath. For each test it presents the two parameter words, pulses start, waits for the write-result strobe and accumulates pass/fail statistics. It sits between the CSR block and control_block, so software can run a batch of tests without polling between them.

---
 rtl/test_sequencer.sv | 274 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/test_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : test_sequencer
//  Purpose  : Queues memory-test parameter sets and launches them back-to-back
//             on control_block, collecting pass/fail statistics per sequence.
//  Options  : SEQ_TIMEOUT_EN - per-test watchdog of TIMEOUT_CYCLES WAIT cycles
//  Revision : 1.0 - initial release
// ============================================================================
module test_sequencer #(
   parameter int QUEUE_DEPTH    = 4,
   parameter int CNT_W          = 8,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                             clk_i,
   input  logic                             rst_n_i,
   input  logic                             push_valid_i,
   input  logic [2:1][31:0]                 push_param_i,
   output logic                             push_ready_o,
   input  logic                             run_i,
   input  logic                             abort_i,
   input  logic                             stop_on_fail_i,
   output logic                             start_test_o,
   output logic [2:1][31:0]                 test_param_reg_o,
   input  logic                             wr_result_i,
   input  logic                             test_result_i,
   output logic                             busy_o,
   output logic                             done_o,
   output logic [$clog2(QUEUE_DEPTH):0]     level_o,
   output logic [CNT_W-1:0]                 pass_cnt_o,
   output logic [CNT_W-1:0]                 fail_cnt_o,
   output logic [CNT_W-1:0]                 first_fail_idx_o,
   output logic                             timeout_o
);

   localparam int              c_ADDR_W  = $clog2(QUEUE_DEPTH);
   localparam int              c_LVL_W   = c_ADDR_W + 1;
   localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_START = 3'd2,
      S_WAIT  = 3'd3,
      S_CHECK = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;

   logic [2:1][31:0]       r_mem [QUEUE_DEPTH];
   logic [c_ADDR_W-1:0]    r_wr_ptr;
   logic [c_ADDR_W-1:0]    r_rd_ptr;
   logic [c_LVL_W-1:0]     r_level;
   logic [2:1][31:0]       r_test_param;

   logic [CNT_W-1:0]       r_pass_cnt;
   logic [CNT_W-1:0]       r_fail_cnt;
   logic [CNT_W-1:0]       r_first_fail;
   logic [CNT_W-1:0]       r_idx;
   logic                   r_last_fail;
   logic                   r_abort_pend;

   logic                   w_full;
   logic                   w_empty;
   logic                   w_flush;
   logic                   w_push;
   logic                   w_pop;
   logic                   w_run_ok;
   logic                   w_timeout;
   logic                   w_finish;
   logic                   w_finish_fail;
   logic                   w_start;
   logic                   w_done;

   assign w_full   = (r_level == c_LVL_W'(QUEUE_DEPTH));
   assign w_empty  = (r_level == '0);
   // A watchdog expiry empties the queue just like an abort.
   assign w_flush  = abort_i | w_timeout;
   // A full queue refuses pushes even when a pop happens in the same cycle.
   assign w_push   = push_valid_i & ~w_full & ~w_flush;
   assign w_pop    = (r_state == S_LOAD) & ~w_empty & ~w_flush;
   assign w_run_ok = (r_state == S_IDLE) & run_i & ~w_empty;

   // A test ends either on the result strobe or on watchdog expiry (a failure).
   assign w_finish      = ((r_state == S_WAIT) & wr_result_i) | w_timeout;
   assign w_finish_fail = ((r_state == S_WAIT) & wr_result_i) ? test_result_i : 1'b1;

`ifdef SEQ_TIMEOUT_EN
   localparam int c_TO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [c_TO_W-1:0] r_wait_cnt;
   logic              r_timeout;

   assign w_timeout = (r_state == S_WAIT) & ~wr_result_i &
                      (r_wait_cnt == c_TO_W'(TIMEOUT_CYCLES - 1));
   assign timeout_o = r_timeout;

   // WAIT-cycle counter; held at zero outside WAIT so every test starts fresh.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_wait_cnt <= '0;
      end else if (r_state != S_WAIT) begin
         r_wait_cnt <= '0;
      end else if (r_wait_cnt != c_TO_W'(TIMEOUT_CYCLES - 1)) begin
         r_wait_cnt <= r_wait_cnt + 1'b1;
      end
   end

   // Sticky watchdog flag, cleared only when a new sequence is accepted.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_timeout <= 1'b0;
      end else if (w_run_ok) begin
         r_timeout <= 1'b0;
      end else if (w_timeout) begin
         r_timeout <= 1'b1;
      end
   end
`else
   assign w_timeout = 1'b0;
   // Watchdog not built: this comparison is constant 0 for any legal limit.
   assign timeout_o = (TIMEOUT_CYCLES < 0);
`endif

   // Parameter storage; no reset needed, validity is tracked by the level.
   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= push_param_i;
      end
   end

   // Queue pointers and occupancy; a flush discards everything at once.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else if (w_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

   // Parameter register for control_block, updated only in LOAD.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_test_param <= '0;
      end else if ((r_state == S_LOAD) && !w_empty) begin
         r_test_param <= r_mem[r_rd_ptr];
      end
   end

   // Saturating statistics and test index, restarted by an accepted run.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_pass_cnt   <= '0;
         r_fail_cnt   <= '0;
         r_first_fail <= c_CNT_MAX;
         r_idx        <= '0;
         r_last_fail  <= 1'b0;
      end else if (w_run_ok) begin
         r_pass_cnt   <= '0;
         r_fail_cnt   <= '0;
         r_first_fail <= c_CNT_MAX;
         r_idx        <= '0;
         r_last_fail  <= 1'b0;
      end else if (w_finish) begin
         r_last_fail <= w_finish_fail;
         if (!w_finish_fail) begin
            if (r_pass_cnt != c_CNT_MAX) begin
               r_pass_cnt <= r_pass_cnt + 1'b1;
            end
         end else begin
            if (r_fail_cnt != c_CNT_MAX) begin
               r_fail_cnt <= r_fail_cnt + 1'b1;
            end
            // fail count is still zero only for the first failure
            if (r_fail_cnt == '0) begin
               r_first_fail <= r_idx;
            end
         end
      end else if ((r_state == S_CHECK) && (r_idx != c_CNT_MAX)) begin
         r_idx <= r_idx + 1'b1;
      end
   end

   // Abort request remembered until the sequence reaches DONE.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_abort_pend <= 1'b0;
      end else if (r_state == S_DONE) begin
         r_abort_pend <= 1'b0;
      end else if (abort_i && (r_state != S_IDLE)) begin
         r_abort_pend <= 1'b1;
      end
   end

   // State register.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode and Moore strobes.
   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_run_ok) begin
               w_state_nxt = S_LOAD;
            end
         end
         S_LOAD: begin
            w_state_nxt = S_START;
         end
         S_START: begin
            w_start     = 1'b1;
            w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (w_finish) begin
               w_state_nxt = S_CHECK;
            end
         end
         S_CHECK: begin
            // an abort arriving in this very cycle empties the queue too
            if (w_empty || r_abort_pend || abort_i || (stop_on_fail_i && r_last_fail)) begin
               w_state_nxt = S_DONE;
            end else begin
               w_state_nxt = S_LOAD;
            end
         end
         S_DONE: begin
            w_done      = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign push_ready_o     = ~w_full;
   assign start_test_o     = w_start;
   assign done_o           = w_done;
   assign busy_o           = (r_state != S_IDLE);
   assign level_o          = r_level;
   assign test_param_reg_o = r_test_param;
   assign pass_cnt_o       = r_pass_cnt;
   assign fail_cnt_o       = r_fail_cnt;
   assign first_fail_idx_o = r_first_fail;

endmodule
`default_nettype wire
